// File: rtl/goertzel_pkg.sv
// Shared Goertzel types: FSM states, elaboration-time cos/sin
// coefficient generators and output saturation.
package goertzel_pkg;

  typedef enum logic [1:0] {
    LOAD,
    INIT,
    RUN
  } state_t;

  localparam int     TRIG_Q   = 28;
  localparam longint TRIG_ONE = 64'sd1 <<< TRIG_Q;
  localparam longint PI_Q     = 64'sd843314857;

  // Taylor series over one quadrant, rotated into place so that
  // the axis angles come out exact before truncation.
  function automatic longint trig_q(
    input int k,
    input int n,
    input bit is_sin
  );
    longint x, c, s, tc, ts, rc, rs;
    int m, q4, q, r;
    m = k % n;
    if (m < 0) m += n;
    q4 = n / 4;
    q = m / q4;
    r = m % q4;
    x = (2 * PI_Q * longint'(r)) / longint'(n);
    c = TRIG_ONE;
    tc = TRIG_ONE;
    s = x;
    ts = x;
    for (int i = 1; i <= 12; i++) begin
      tc = -(((tc * x) / TRIG_ONE) * x / TRIG_ONE)
           / longint'((2 * i - 1) * (2 * i));
      ts = -(((ts * x) / TRIG_ONE) * x / TRIG_ONE)
           / longint'((2 * i) * (2 * i + 1));
      c += tc;
      s += ts;
    end
    case (q)
      0: begin
        rc = c;
        rs = s;
      end
      1: begin
        rc = -s;
        rs = c;
      end
      2: begin
        rc = -c;
        rs = -s;
      end
      default: begin
        rc = s;
        rs = -c;
      end
    endcase
    return is_sin ? rs : rc;
  endfunction

  function automatic int cos_coef(
    input int k,
    input int n,
    input int frac
  );
    return int'((trig_q(k, n, 1'b0) * (64'sd1 <<< frac))
                / TRIG_ONE);
  endfunction

  function automatic int sin_coef(
    input int k,
    input int n,
    input int frac
  );
    return int'((trig_q(k, n, 1'b1) * (64'sd1 <<< frac))
                / TRIG_ONE);
  endfunction

  function automatic longint sat(
    input longint v,
    input int w
  );
    longint hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/goertzel_synth_if.sv
// Bin load port and sample stream port of the Goertzel
// synthesizer, both valid/ready.
interface goertzel_synth_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] i_re;
  logic signed [WIDTH-1:0] i_im;
  logic                    i_valid;
  logic                    o_ready;
  logic signed [WIDTH-1:0] o_y;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_last;
  logic                    o_busy;

  modport master (
    output i_re,
    output i_im,
    output i_valid,
    output i_ready,
    input  o_ready,
    input  o_y,
    input  o_valid,
    input  o_last,
    input  o_busy
  );

  modport slave (
    input  i_re,
    input  i_im,
    input  i_valid,
    input  i_ready,
    output o_ready,
    output o_y,
    output o_valid,
    output o_last,
    output o_busy
  );
endinterface

// File: rtl/goertzel_osc.sv
// One second-order resonator: seeded from a complex bin, then
// stepped with y[n+2] = (2*C*y[n+1] >>> F) - y[n], wrapping.
module goertzel_osc
  import goertzel_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 4,
  parameter int COS_K     = 16,
  parameter int SIN_K     = 0
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst_n,
  input  logic                    init,
  input  logic                    advance,
  input  logic signed [WIDTH-1:0] re,
  input  logic signed [WIDTH-1:0] im,
  output logic signed [WIDTH-1:0] y
);

  localparam int PW = 2 * WIDTH + 2;
  localparam logic signed [PW-1:0] C1 = PW'(COS_K);
  localparam logic signed [PW-1:0] S1 = PW'(SIN_K);
  localparam logic signed [PW-1:0] C2 = PW'(2 * COS_K);

  logic signed [WIDTH-1:0] y0;
  logic signed [WIDTH-1:0] y1;

  always_ff @(negedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      y0 <= '0;
      y1 <= '0;
    end else if (init) begin
      y0 <= re;
      y1 <= WIDTH'((PW'(re) * C1 - PW'(im) * S1)
                   >>> FRAC_BITS);
    end else if (advance) begin
      y0 <= y1;
      y1 <= WIDTH'(((C2 * PW'(y1)) >>> FRAC_BITS)
                   - PW'(y0));
    end
  end

  assign y = y0;

endmodule

// File: rtl/goertzel_synth.sv
// Goertzel synthesizer: loads complex bins, then streams one
// N_MAX frame summed from one resonator per bin.
module goertzel_synth
  import goertzel_pkg::*;
#(
  parameter int N_MAX       = 32,
  parameter int WIDTH       = 16,
  parameter int BIN_NUM     = 1,
  parameter int FRAC_BITS   = 4,
  parameter int SCALE_SHIFT = 0
) (
  input logic            i_sys_clk,
  input logic            i_sys_rst_n,
  goertzel_synth_if.slave bus
);

  localparam int PB = (BIN_NUM > 1) ? $clog2(BIN_NUM) : 1;
  localparam int CW = $clog2(N_MAX);
  localparam int SW = WIDTH + $clog2(BIN_NUM) + 1;

  state_t                  state;
  logic [PB-1:0]           ptr;
  logic [CW-1:0]           cnt;
  logic signed [WIDTH-1:0] re_q [BIN_NUM];
  logic signed [WIDTH-1:0] im_q [BIN_NUM];
  logic signed [WIDTH-1:0] y_b  [BIN_NUM];
  logic signed [SW-1:0]    sum;
  logic signed [WIDTH-1:0] y_nxt;
  logic                    init;
  logic                    done;
  logic                    emit;

  assign init = (state == INIT);
  assign done = (state == RUN) && bus.o_valid
              && bus.o_last && bus.i_ready;
  // Resonators run one sample ahead of o_y, so they step
  // whenever the output register takes a new sample.
  assign emit = (state == RUN) && !done
              && (!bus.o_valid || bus.i_ready);

  assign bus.o_ready = (state == LOAD);
  assign bus.o_busy  = (state != LOAD);

  for (genvar b = 0; b < BIN_NUM; b++) begin : g_bin
    goertzel_osc #(
      .WIDTH    (WIDTH),
      .FRAC_BITS(FRAC_BITS),
      .COS_K    (cos_coef(b + 1, N_MAX, FRAC_BITS)),
      .SIN_K    (sin_coef(b + 1, N_MAX, FRAC_BITS))
    ) u_osc (
      .i_sys_clk  (i_sys_clk),
      .i_sys_rst_n(i_sys_rst_n),
      .init       (init),
      .advance    (emit),
      .re         (re_q[b]),
      .im         (im_q[b]),
      .y          (y_b[b])
    );
  end

  always_comb begin
    sum = '0;
    for (int b = 0; b < BIN_NUM; b++) begin
      sum += SW'(y_b[b]);
    end
    y_nxt = WIDTH'(sat(64'(sum >>> SCALE_SHIFT), WIDTH));
  end

  always_ff @(negedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state       <= LOAD;
      ptr         <= '0;
      cnt         <= '0;
      bus.o_y     <= '0;
      bus.o_valid <= 1'b0;
      bus.o_last  <= 1'b0;
      for (int b = 0; b < BIN_NUM; b++) begin
        re_q[b] <= '0;
        im_q[b] <= '0;
      end
    end else begin
      unique case (state)
        LOAD: begin
          if (bus.i_valid) begin
            re_q[ptr] <= bus.i_re;
            im_q[ptr] <= bus.i_im;
            if (ptr == PB'(BIN_NUM - 1)) begin
              ptr   <= '0;
              state <= INIT;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        INIT: state <= RUN;
        RUN: begin
          if (done) begin
            state       <= LOAD;
            cnt         <= '0;
            bus.o_valid <= 1'b0;
            bus.o_last  <= 1'b0;
          end else if (emit) begin
            bus.o_y     <= y_nxt;
            bus.o_valid <= 1'b1;
            bus.o_last  <= (cnt == CW'(N_MAX - 1));
            cnt         <= cnt + 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_goertzel_synth.sv
// Randomized self-checking bench for goertzel_synth, checked
// against a frame model built from the resonator equations.
module tb_goertzel_synth;

  localparam int N = 32;
  localparam int W = 16;
  localparam int F = 4;

  logic clk;
  logic rst_n;
  logic sel;
  logic drv_valid;
  logic drv_ready;
  logic signed [W-1:0] drv_re;
  logic signed [W-1:0] drv_im;

  int n_tests;
  int n_fail;
  longint ld_re [2];
  longint ld_im [2];
  longint exp_y [N];

  goertzel_synth_if #(.WIDTH(W)) b1 ();
  goertzel_synth_if #(.WIDTH(W)) b2 ();

  assign b1.i_re    = drv_re;
  assign b1.i_im    = drv_im;
  assign b1.i_valid = drv_valid && !sel;
  assign b1.i_ready = drv_ready && !sel;
  assign b2.i_re    = drv_re;
  assign b2.i_im    = drv_im;
  assign b2.i_valid = drv_valid && sel;
  assign b2.i_ready = drv_ready && sel;

  logic signed [W-1:0] ob_y;
  logic ob_valid, ob_ready, ob_last, ob_busy;

  assign ob_y     = sel ? b2.o_y     : b1.o_y;
  assign ob_valid = sel ? b2.o_valid : b1.o_valid;
  assign ob_ready = sel ? b2.o_ready : b1.o_ready;
  assign ob_last  = sel ? b2.o_last  : b1.o_last;
  assign ob_busy  = sel ? b2.o_busy  : b1.o_busy;

  goertzel_synth #(
    .N_MAX(N), .WIDTH(W), .BIN_NUM(1),
    .FRAC_BITS(F), .SCALE_SHIFT(0)
  ) u_dut1 (
    .i_sys_clk  (clk),
    .i_sys_rst_n(rst_n),
    .bus        (b1.slave)
  );

  goertzel_synth #(
    .N_MAX(N), .WIDTH(W), .BIN_NUM(2),
    .FRAC_BITS(F), .SCALE_SHIFT(0)
  ) u_dut2 (
    .i_sys_clk  (clk),
    .i_sys_rst_n(rst_n),
    .bus        (b2.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic check(
    input string tag,
    input logic signed [63:0] got,
    input logic signed [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap(input longint v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return longint'(t);
  endfunction

  function automatic longint fdiv(input longint a, input longint d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic longint clamp(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic build_model(input int nb);
    longint y [N];
    longint acc [N];
    longint c, s;
    real pi;
    pi = 3.14159265358979;
    for (int n = 0; n < N; n++) acc[n] = 0;
    for (int b = 0; b < nb; b++) begin
      c = longint'($rtoi($cos(2.0 * pi * (b + 1) / N) * (1 << F)));
      s = longint'($rtoi($sin(2.0 * pi * (b + 1) / N) * (1 << F)));
      y[0] = ld_re[b];
      y[1] = wrap(fdiv(ld_re[b] * c - ld_im[b] * s, 1 << F));
      for (int n = 2; n < N; n++)
        y[n] = wrap(fdiv(2 * c * y[n-1], 1 << F) - y[n-2]);
      for (int n = 0; n < N; n++) acc[n] += y[n];
    end
    for (int n = 0; n < N; n++) exp_y[n] = clamp(acc[n]);
  endtask

  task automatic rand_bins();
    logic signed [W-1:0] t;
    for (int b = 0; b < 2; b++) begin
      t = W'($urandom_range(65535));
      ld_re[b] = t;
      t = W'($urandom_range(65535));
      ld_im[b] = t;
    end
  endtask

  // mode 0: ready high, 1: random ready, 2: 3-cycle stall at n=1
  task automatic run_frame(
    input int nb,
    input int mode,
    input bit junk,
    input int abort_at
  );
    int idx, cyc, lat, hold;
    build_model(nb);
    check("ready_idle", ob_ready, 1);
    for (int b = 0; b < nb; b++) begin
      drv_re = W'(ld_re[b]);
      drv_im = W'(ld_im[b]);
      drv_valid = 1'b1;
      @(posedge clk);
    end
    drv_valid = 1'b0;
    check("busy_init", ob_busy, 1);
    check("ready_init", ob_ready, 0);
    lat = 1;
    while (!ob_valid && lat < 10) begin
      @(posedge clk);
      lat++;
    end
    check("latency", lat, 3);
    idx = 0;
    cyc = 0;
    hold = 0;
    while (idx < N && cyc < 400) begin
      check("valid", ob_valid, 1);
      check("y", ob_y, exp_y[idx]);
      check("last", ob_last, idx == N - 1);
      check("busy_run", ob_busy, 1);
      if (idx == abort_at) begin
        rst_n = 1'b0;
        drv_ready = 1'b0;
        drv_valid = 1'b0;
        #1;
        check("rst_valid", ob_valid, 0);
        check("rst_y", ob_y, 0);
        check("rst_ready", ob_ready, 1);
        check("rst_last", ob_last, 0);
        @(posedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        check("post_rst_valid", ob_valid, 0);
        check("post_rst_busy", ob_busy, 0);
        return;
      end
      case (mode)
        1: drv_ready = ($urandom_range(2) != 0);
        2: begin
          drv_ready = !(idx == 1 && hold < 3);
          if (!drv_ready) hold++;
        end
        default: drv_ready = 1'b1;
      endcase
      if (junk) begin
        drv_valid = 1'($urandom_range(1));
        drv_re = W'($urandom_range(65535));
        drv_im = W'($urandom_range(65535));
      end
      if (drv_ready) idx++;
      @(posedge clk);
      cyc++;
    end
    drv_ready = 1'b0;
    drv_valid = 1'b0;
    check("handshakes", idx, N);
    check("end_valid", ob_valid, 0);
    check("end_ready", ob_ready, 1);
    check("end_busy", ob_busy, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    sel = 1'b0;
    drv_valid = 1'b0;
    drv_ready = 1'b0;
    drv_re = '0;
    drv_im = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    check("rst0_valid", ob_valid, 0);
    check("rst0_y", ob_y, 0);
    rst_n = 1'b1;
    @(posedge clk);
    check("idle_ready", ob_ready, 1);
    check("idle_busy", ob_busy, 0);
    check("idle_last", ob_last, 0);

    ld_re[0] = 64;
    ld_im[0] = 0;
    run_frame(1, 0, 1'b0, -1);
    ld_re[0] = 0;
    ld_im[0] = 64;
    run_frame(1, 0, 1'b0, -1);
    ld_re[0] = 64;
    ld_im[0] = 0;
    run_frame(1, 2, 1'b0, -1);
    repeat (4) begin
      rand_bins();
      run_frame(1, 1, 1'b1, -1);
    end
    ld_re[0] = 64;
    ld_im[0] = 0;
    run_frame(1, 1, 1'b0, 10);
    run_frame(1, 0, 1'b1, -1);

    sel = 1'b1;
    @(posedge clk);
    ld_re[0] = 32767;
    ld_im[0] = 0;
    ld_re[1] = 32767;
    ld_im[1] = 0;
    run_frame(2, 0, 1'b0, -1);
    rand_bins();
    run_frame(2, 1, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/goertzel_synth.md
# goertzel_synth

Inverse companion to the Goertzel bin analyzer. Accepts BIN_NUM complex bin values (re, im) over a valid/ready load port. Regenerates an N_MAX-sample time-domain frame by running one second-order resonator per bin and summing their outputs. Sits downstream of the analyzer (or a bin-domain processing stage) and streams samples out over a valid/ready port with a frame-last marker.

## Interface

- N_MAX, 32: frame length in samples; power of two.
- WIDTH, 16: signed fixed-point width of all bin and sample data.
- BIN_NUM, 1: number of bins; bin b uses frequency index k = b+1.
- FRAC_BITS, 4: fractional bits of the cos/sin coefficients.
- SCALE_SHIFT, 0: arithmetic right shift applied to the bin sum before saturation.
- i_sys_clk in 1: single clock; all registers update on the falling edge, matching the analyzer.
- i_sys_rst_n in 1: reset, asynchronous, active-low.
- i_re in WIDTH: signed real part of the bin being loaded.
- i_im in WIDTH: signed imaginary part of the bin being loaded.
- i_valid in 1: load beat valid.
- o_ready out 1: load port ready; high only in LOAD.
- o_y out WIDTH: signed output sample.
- o_valid out 1: o_y valid.
- i_ready in 1: downstream ready.
- o_last out 1: high with the final sample (n = N_MAX-1) of a frame.
- o_busy out 1: high in any state other than LOAD.

## Operation

- Coefficients: C_k = trunc(cos(2πk/N_MAX)·2^FRAC_BITS) and S_k = trunc(sin(2πk/N_MAX)·2^FRAC_BITS), truncated toward zero and elaboration-time constant.
- **States:** LOAD → INIT → RUN → LOAD.
- **LOAD:** o_ready=1. Each i_valid beat stores (i_re, i_im) into the bin at load pointer p, then increments p. The beat with p = BIN_NUM-1 clears p and moves to INIT.
- **INIT (one cycle):** each bin b initializes its resonator:
  - y_b[0] = Re_b
  - y_b[1] = (Re_b·C_k − Im_b·S_k) >>> FRAC_BITS
- **RUN:** presents sample n, where s[n] = Σ_b y_b[n].
  - o_y = sat_WIDTH(s[n] >>> SCALE_SHIFT).
  - On each o_valid && i_ready handshake, every resonator advances: y[n+2] = ((2·C_k·y[n+1]) >>> FRAC_BITS) − y[n].
  - Handshake at n = N_MAX-1 (o_last=1) → LOAD.
- **Arithmetic:**
  - Products are full width (2·WIDTH+2).
  - `>>>` is a floor shift.
  - Resonator state wraps at WIDTH bits; it does not saturate.
  - Bin sum width is WIDTH + clog2(BIN_NUM) + 1.
  - Only the final output saturates, to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- **Stall:** with o_valid=1 and i_ready=0, o_y, o_last and all resonator state hold.
- **Illegal input:** i_valid outside LOAD is ignored; no data is captured.
- **Reset (any state, including mid-frame or mid-load):**
  - State → LOAD, p=0, n=0, resonators and bin store cleared.
  - o_valid=0, o_last=0, o_y=0, o_busy=0, o_ready=1 once reset releases.
  - A partially emitted frame is discarded.

## Timing

- Load accepts one bin per cycle, BIN_NUM cycles minimum.
- First o_valid is asserted at the second falling edge after the last load handshake: one INIT edge, then one edge to register sample 0.
- Output rate is one sample per cycle with i_ready held high.
- Frame throughput is BIN_NUM + 1 + N_MAX + 1 cycles, with no overlap between load and run.
- o_y, o_valid and o_last are registered. o_ready and o_busy are decoded from state.

## Structure

- The shared package goertzel_pkg holds:
  - the state enum (LOAD, INIT, RUN);
  - the coefficient functions cos_coef(k) and sin_coef(k), shared with the analyzer;
  - a sat function for WIDTH saturation.
- Sub-module goertzel_osc, one instance per bin:
  - holds y[n] and y[n+1] for one resonator;
  - inputs: init, advance, Re, Im;
  - output: y[n].
- The top level holds the FSM, the load pointer, the sample counter, the adder tree and the output register.

## Test plan

All scenarios use N_MAX=32, WIDTH=16, FRAC_BITS=4, BIN_NUM=1, SCALE_SHIFT=0 unless stated (C_1=15, S_1=3).

- **Real bin:** load (64, 0), i_ready=1 → o_y = 64, 60, 48, … for 32 samples; o_last only on the 32nd; then o_ready=1.
- **Imaginary bin:** load (0, 64) → o_y = 0, −12, −23, ….
- **Backpressure:** same as the real-bin case with i_ready low for 3 cycles at n=1 → o_y holds 60 with o_valid=1, then resumes 48; exactly 32 handshakes.
- **Saturation:** BIN_NUM=2, load (32767, 0) into both bins → o_y[0] = 32767, not a wrapped value.
- **Mid-frame reset:** assert i_sys_rst_n low at n=10, then release → o_valid=0, o_y=0, o_ready=1. Reloading (64, 0) restarts the sequence at 64.
- **Illegal beats:** i_valid pulses during RUN → ignored; output sequence unchanged.
